// File: rtl/alu_mc.sv
// Multi-cycle MIPS-lite ALU: registered single-cycle ALU ops plus iterative unsigned
// MULU (shift-add) and DIVU (restoring), with a start/busy/done handshake.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zout,
    output logic             vout,
    output logic             nout,
    output logic             dbz,
    output logic             busy,
    output logic             done
);
    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(WIDTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_r, next_state_s;
    logic [CNTW-1:0]  count_r;
    logic [WIDTH-1:0] work_hi_r, work_lo_r, opnd_r;
    logic             is_div_r;
    logic [WIDTH-1:0] sum_s, diff_s, sc_res_s, step_hi_s, step_lo_s;
    logic             add_ovf_s, sub_ovf_s, sc_vout_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s, div_trial_s;
    logic             accept_s, multi_s, last_s;

    assign accept_s = (state_r == IDLE) && start;
    assign multi_s  = (op == OP_MULU) || ((op == OP_DIVU) && (b != {WIDTH{1'b0}}));
    assign last_s   = (state_r == RUN) && (count_r == CNT_ONE);

    // Single-cycle ALU result and overflow; SUB is formed as a + ~b + 1
    always_comb begin
        sum_s     = a + b;
        diff_s    = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
        add_ovf_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
        sub_ovf_s = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
        sc_res_s  = {WIDTH{1'b0}};
        sc_vout_s = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res_s  = sum_s;
                sc_vout_s = add_ovf_s;
            end
            OP_SUB: begin
                sc_res_s  = diff_s;
                sc_vout_s = sub_ovf_s;
            end
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, diff_s[MSB] ^ sub_ovf_s};
            OP_AND:  sc_res_s = a & b;
            OP_OR:   sc_res_s = a | b;
            OP_NOR:  sc_res_s = ~(a | b);
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One iteration: work_hi:work_lo is the product pair for MULU, remainder:quotient for DIVU
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {work_hi_r, work_lo_r[MSB]};
        div_trial_s = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (div_trial_s[WIDTH]) begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
            end else begin
                step_hi_s = div_trial_s[WIDTH-1:0];
                step_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && multi_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, iteration registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= {CNTW{1'b0}};
            work_hi_r <= {WIDTH{1'b0}};
            work_lo_r <= {WIDTH{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            result    <= {WIDTH{1'b0}};
            hi        <= {WIDTH{1'b0}};
            zout      <= 1'b1;
            vout      <= 1'b0;
            nout      <= 1'b0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (accept_s) begin
            if (multi_s) begin
                work_hi_r <= {WIDTH{1'b0}};
                work_lo_r <= (op == OP_DIVU) ? a : b;
                opnd_r    <= (op == OP_DIVU) ? b : a;
                is_div_r  <= (op == OP_DIVU);
                count_r   <= CNT_INIT;
                busy      <= 1'b1;
                done      <= 1'b0;
            end else if (op == OP_DIVU) begin
                // Divide by zero completes at once with an all-ones quotient
                result <= {WIDTH{1'b1}};
                hi     <= a;
                zout   <= 1'b0;
                vout   <= 1'b0;
                nout   <= 1'b1;
                dbz    <= 1'b1;
                done   <= 1'b1;
            end else begin
                result <= sc_res_s;
                hi     <= {WIDTH{1'b0}};
                zout   <= (sc_res_s == {WIDTH{1'b0}});
                vout   <= sc_vout_s;
                nout   <= sc_res_s[MSB];
                dbz    <= 1'b0;
                done   <= 1'b1;
            end
        end else if (state_r == RUN) begin
            work_hi_r <= step_hi_s;
            work_lo_r <= step_lo_s;
            count_r   <= count_r - CNT_ONE;
            if (last_s) begin
                result <= step_lo_s;
                hi     <= step_hi_s;
                zout   <= is_div_r ? (step_lo_s == {WIDTH{1'b0}})
                                   : ({step_hi_s, step_lo_s} == {(2*WIDTH){1'b0}});
                vout   <= 1'b0;
                nout   <= step_lo_s[MSB];
                dbz    <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
            end else begin
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc: a cycle-level reference model for the
// 32-bit instance plus directed scenarios on 32-bit and 8-bit instances.
module tb_alu_mc;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    logic        clk, reset, start, start8;
    logic [3:0]  op, op8;
    logic [31:0] a, b, result, hi;
    logic [7:0]  a8, b8, result8, hi8;
    logic        zout, vout, nout, dbz, busy, done;
    logic        zout8, vout8, nout8, dbz8, busy8, done8;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    alu_mc #(.WIDTH(32), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .hi(hi), .zout(zout), .vout(vout), .nout(nout),
        .dbz(dbz), .busy(busy), .done(done)
    );

    alu_mc #(.WIDTH(8), .CNTW(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .result(result8), .hi(hi8), .zout(zout8), .vout(vout8), .nout(nout8),
        .dbz(dbz8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference computed from signed/unsigned integer values
    function automatic void model(input int w, input logic [3:0] o, input logic [63:0] x,
                                  input logic [63:0] y, output logic [63:0] r,
                                  output logic [63:0] h, output logic z, output logic v,
                                  output logic n, output logic d);
        logic [63:0] mask, p;
        longint sx, sy, s, lim;
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(64'd1 << (w - 1));
        sx = longint'(x);
        sy = longint'(y);
        if (x[w-1]) sx = sx - 2 * lim;
        if (y[w-1]) sy = sy - 2 * lim;
        r = 64'd0; h = 64'd0; v = 1'b0; d = 1'b0; p = 64'd0;
        case (o)
            OP_ADD: begin r = (x + y) & mask; s = sx + sy; v = (s >= lim) || (s < -lim); end
            OP_SUB: begin r = (x - y) & mask; s = sx - sy; v = (s >= lim) || (s < -lim); end
            OP_SLT: r = (sx < sy) ? 64'd1 : 64'd0;
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_NOR: r = ~(x | y) & mask;
            OP_MULU: begin p = x * y; r = p & mask; h = p >> w; end
            OP_DIVU: begin
                if (y == 64'd0) begin r = mask; h = x; d = 1'b1; end
                else begin r = x / y; h = x % y; end
            end
            default: r = 64'd0;
        endcase
        z = (o == OP_MULU) ? (p == 64'd0) : (r == 64'd0);
        n = r[w-1];
    endfunction

    // Cycle-level expectation for the 32-bit instance
    int          m_left;
    logic        m_done, m_z, m_v, m_n, m_d, p_z, p_v, p_n, p_d;
    logic [31:0] m_res, m_hi, p_res, p_hi;

    always @(posedge clk or posedge reset) begin
        logic [63:0] r, h;
        logic z, v, n, d;
        if (reset) begin
            m_left <= 0; m_done <= 1'b0; m_res <= 32'd0; m_hi <= 32'd0;
            m_z <= 1'b1; m_v <= 1'b0; m_n <= 1'b0; m_d <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_res <= p_res; m_hi <= p_hi; m_z <= p_z; m_v <= p_v; m_n <= p_n; m_d <= p_d;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                model(32, op, {32'd0, a}, {32'd0, b}, r, h, z, v, n, d);
                if (op == OP_MULU || (op == OP_DIVU && b != 32'd0)) begin
                    p_res <= r[31:0]; p_hi <= h[31:0]; p_z <= z; p_v <= v; p_n <= n; p_d <= d;
                    m_left <= 32;
                end else begin
                    m_res <= r[31:0]; m_hi <= h[31:0]; m_z <= z; m_v <= v; m_n <= n; m_d <= d;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of the 32-bit instance against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 64'(busy), 64'(m_left > 0));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_result", 64'(result), 64'(m_res));
            check("cyc_hi", 64'(hi), 64'(m_hi));
            check("cyc_zout", 64'(zout), 64'(m_z));
            check("cyc_vout", 64'(vout), 64'(m_v));
            check("cyc_nout", 64'(nout), 64'(m_n));
            check("cyc_dbz", 64'(dbz), 64'(m_d));
        end
    end

    task automatic issue(input bit w8, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        if (w8) begin op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
        else begin op = o; a = x; b = y; start = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0;
        start8 = 1'b0;
    endtask

    // Starts one cycle after the accepting edge; k ends as the cycle in which done is seen
    task automatic wait_done(input bit w8, input bit toggle, output int k, output int bc);
        k = 1;
        bc = 0;
        while (((w8 ? done8 : done) == 1'b0) && k < 100) begin
            if (w8 ? busy8 : busy) bc++;
            if (toggle) begin
                a = $urandom; b = $urandom; op = 4'($urandom); start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            k++;
        end
        if (toggle) start = 1'b0;
    endtask

    task automatic expect32(input string nm, input logic [31:0] r, input logic [31:0] h,
                            input logic z, input logic v, input logic n, input logic d);
        check({nm, "_result"}, 64'(result), 64'(r));
        check({nm, "_hi"}, 64'(hi), 64'(h));
        check({nm, "_zout"}, 64'(zout), 64'(z));
        check({nm, "_vout"}, 64'(vout), 64'(v));
        check({nm, "_nout"}, 64'(nout), 64'(n));
        check({nm, "_dbz"}, 64'(dbz), 64'(d));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            5: return 32'($urandom_range(0, 300));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] ops [8];
        ops = '{OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_NOR, OP_MULU, OP_DIVU};
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return ops[$urandom_range(0, 7)];
    endfunction

    initial begin
        int k, bc;
        logic [3:0]  o;
        logic [31:0] x, y;
        logic [63:0] r, h;
        logic z, v, n, d;
        reset = 1'b1; start = 1'b0; start8 = 1'b0;
        op = 4'd0; a = 32'd0; b = 32'd0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        expect32("rst", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst8_zout", 64'(zout8), 64'd1);

        issue(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        wait_done(1'b0, 1'b0, k, bc);
        check("add_latency", 64'(k), 64'd1);
        expect32("add", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        issue(1'b0, OP_SLT, 32'h8000_0000, 32'd1);
        wait_done(1'b0, 1'b0, k, bc);
        check("slt_latency", 64'(k), 64'd1);
        expect32("slt", 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(1'b0, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, 1'b0, k, bc);
        check("mulu_latency", 64'(k), 64'd33);
        check("mulu_busy_cycles", 64'(bc), 64'd32);
        expect32("mulu", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(1'b0, OP_DIVU, 32'd100, 32'd7);
        wait_done(1'b0, 1'b1, k, bc);
        check("divu_latency", 64'(k), 64'd33);
        expect32("divu", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            check("divu_no_extra_done", 64'(done), 64'd0);
        end

        issue(1'b0, OP_DIVU, 32'd5, 32'd0);
        wait_done(1'b0, 1'b0, k, bc);
        check("dbz_latency", 64'(k), 64'd1);
        check("dbz_busy", 64'(busy), 64'd0);
        expect32("dbz", 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, OP_AND, 32'hF0, 32'h0F);
        wait_done(1'b0, 1'b0, k, bc);
        expect32("and_after_dbz", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        issue(1'b0, OP_OR, 32'h12, 32'h34);
        wait_done(1'b0, 1'b0, k, bc);
        issue(1'b0, OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) begin @(posedge clk); #1; end
        check("pre_reset_busy", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        expect32("async_rst", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            check("no_done_after_abort", 64'(done), 64'd0);
        end
        issue(1'b0, OP_ADD, 32'd2, 32'd3);
        wait_done(1'b0, 1'b0, k, bc);
        check("add_after_reset", 64'(result), 64'd5);

        for (int i = 0; i < 150; i++) begin
            o = pick_op();
            x = pick();
            y = pick();
            issue(1'b0, o, x, y);
            wait_done(1'b0, 1'b0, k, bc);
            check("rand_latency", 64'(k),
                  (o == OP_MULU || (o == OP_DIVU && y != 32'd0)) ? 64'd33 : 64'd1);
        end

        issue(1'b1, OP_MULU, 32'hFF, 32'h02);
        wait_done(1'b1, 1'b0, k, bc);
        check("w8_mulu_latency", 64'(k), 64'd9);
        check("w8_mulu_busy_cycles", 64'(bc), 64'd8);
        check("w8_mulu_hi", 64'(hi8), 64'h01);
        check("w8_mulu_result", 64'(result8), 64'hFE);
        issue(1'b1, 4'b1111, 32'h5A, 32'hA5);
        wait_done(1'b1, 1'b0, k, bc);
        check("w8_illegal_latency", 64'(k), 64'd1);
        check("w8_illegal_done", 64'(done8), 64'd1);
        check("w8_illegal_result", 64'(result8), 64'd0);
        check("w8_illegal_zout", 64'(zout8), 64'd1);

        for (int i = 0; i < 40; i++) begin
            o = pick_op();
            x = {24'd0, 8'($urandom)};
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : {24'd0, 8'($urandom)};
            issue(1'b1, o, x, y);
            wait_done(1'b1, 1'b0, k, bc);
            model(8, o, {32'd0, x}, {32'd0, y}, r, h, z, v, n, d);
            check("w8_rand_latency", 64'(k),
                  (o == OP_MULU || (o == OP_DIVU && y != 32'd0)) ? 64'd9 : 64'd1);
            check("w8_rand_result", 64'(result8), r);
            check("w8_rand_hi", 64'(hi8), h);
            check("w8_rand_flags", {60'd0, zout8, vout8, nout8, dbz8}, {60'd0, z, v, n, d});
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS-lite ALU, generalised to WIDTH bits.
- Keeps the legacy single-cycle operations: ADD, SUB, SLT, AND, OR, NOR.
- Fixes legacy flag and compare behaviour: signed-correct SLT, defined vout.
- Adds unsigned iterative multiply and divide, driven by a start/busy/done handshake. Results go to a result/hi pair (HI/LO style).
- Sits in the EX stage of the multi-cycle datapath; control stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (≥4)
CNTW, 6, width of the iteration counter; must satisfy 2^CNTW > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled only in IDLE
op  input  4  operation select (encoding below)
a  input  WIDTH  operand A (dividend / multiplicand)
b  input  WIDTH  operand B (divisor / multiplier)
result  output  WIDTH  LO: ALU result, product low half, or quotient
hi  output  WIDTH  product high half or remainder; 0 for single-cycle ops
zout  output  1  zero flag
vout  output  1  signed overflow flag
nout  output  1  negative flag, = result[WIDTH-1]
dbz  output  1  divide-by-zero flag
busy  output  1  high while a multi-cycle op is in progress
done  output  1  one-cycle pulse: result, hi and flags updated

Behaviour:
- Reset values:
  - result=0, hi=0, zout=1, vout=0, nout=0, dbz=0, busy=0, done=0
  - state=IDLE, counter=0
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Op encoding:
  - 0010 ADD, 0110 SUB, 0111 SLT, 0000 AND, 0001 OR, 0011 NOR (legacy codes zero-extended)
  - 1000 MULU, 1001 DIVU
  - Any other code: result=0, hi=0
- States:
  - IDLE:
    - start=1 with a single-cycle op or illegal op: compute, register outputs, pulse done; stay IDLE.
    - start=1 with MULU/DIVU: latch a and b, counter=WIDTH, busy=1, go to RUN.
    - start=0: outputs hold, done=0.
  - RUN: one iteration per clock, counter decrements. On the edge where counter reaches 0:
    - register result/hi/flags
    - busy=0, done=1
    - go to IDLE
  - start during RUN is ignored and no queueing is done.
  - A new start is accepted in the cycle where done=1; the state is already IDLE.
- Latency:
  - Single-cycle ops: done high in the cycle after the accepting edge.
  - MULU/DIVU: done high WIDTH+1 cycles after the accepting edge; busy high for exactly WIDTH cycles.
- Arithmetic:
  - ADD/SUB: modulo 2^WIDTH.
    - vout = signed overflow (same-sign operands with a different-sign result; for SUB, compute a + ~b + 1).
  - SLT: result = 1 if a < b signed, computed as diff[MSB] XOR overflow; otherwise 0.
  - Logic ops, SLT, MULU, DIVU: vout=0.
  - MULU: shift-add over 2·WIDTH bits. hi:result = a·b unsigned. zout=1 iff the full 2·WIDTH product is 0.
  - DIVU: restoring division. result = a/b, hi = a mod b (unsigned). zout on the quotient.
  - DIVU with b=0:
    - no iteration; completes like a single-cycle op (done next cycle, busy never set)
    - result = all ones, hi = a, dbz=1
  - dbz clears on the next completion of any other op.
- Flags apply to every op: zout = (result==0), except the MULU rule above; nout = result[WIDTH-1].
- Operands a and b may change after the accepting edge without affecting the operation in progress.

Test Plan:
- WIDTH=32, back-to-back single-cycle ops:
  - ADD 0x7FFFFFFF+1 → result=0x80000000, vout=1, nout=1, done one cycle later.
  - Then SLT a=0x80000000, b=1 → result=1, vout=0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy high 32 cycles, done at cycle 33
  - hi=0xFFFFFFFE, result=0x00000001, zout=0
- DIVU a=100, b=7 → result=14, hi=2, done at cycle 33.
  - Toggle a and b and assert start during RUN: no effect on the result, no extra done.
- DIVU a=5, b=0 → done next cycle, busy stays 0, result=0xFFFFFFFF, hi=5, dbz=1.
  - Following AND 0xF0 & 0x0F → result=0, zout=1, dbz=0.
- Reset at cycle 10 of a MULU:
  - all outputs return to reset values asynchronously
  - no done pulse follows
  - a new ADD 2+3 then gives result=5.
- WIDTH=8 instance: MULU 0xFF×0x02 → hi=0x01, result=0xFE, done at cycle 9.
  - Illegal op 1111 → result=0, zout=1, done pulses.
